ntt_butterfly: RTL and testbench
================================

NTT_BUTTERFLY -- requirements
Module: ntt_butterfly

Interface
REQ-001 SHALL have parameter WIDTH, default 23, coefficient bit width.
REQ-002 SHALL have parameter Q, default 23'd8380417, modulus; 2 < Q < 2^WIDTH, Q odd.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports in_a, in_b, in_w, input, WIDTH each, operands and twiddle factor; the caller keeps each value < Q.
REQ-006 SHALL have port in_mode, input, 1: 0 = Cooley-Tukey (CT), 1 = Gentleman-Sande (GS).
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1), input handshake.
REQ-008 SHALL have ports out_a and out_b (output, WIDTH each), out_valid (output, 1) and out_ready (input, 1), output handshake.

Function
REQ-009 SHALL compute in CT mode: t = b*w mod Q; out_a = (a+t) mod Q; out_b = (a-t) mod Q.
REQ-010 SHALL compute in GS mode: out_a = (a+b) mod Q; out_b = ((a-b) mod Q)*w mod Q.
REQ-011 SHALL fix latency at 5 advancing cycles in both modes.
- CT: 4-stage multiplier, then 1 add/sub stage; in_a delayed 4 stages.
- GS: 1 add/sub stage, then 4-stage multiplier; the sum is delayed 4 stages.
REQ-012 SHALL carry mode and valid alongside data through every stage, so CT and GS beats may interleave back-to-back.
REQ-013 SHALL perform the multiplier as: registered full 2*WIDTH product, then Barrett estimate with a constant M = floor(2^(2*WIDTH)/Q), then registered remainder, then final conditional subtraction(s); result always in [0,Q).
REQ-014 SHALL produce modular add and sub results in [0,Q) with one conditional correction each, using WIDTH+1-bit intermediates.
REQ-015 SHALL advance the whole pipeline when en = out_ready | ~out_valid; when en=0, every stage register holds.
REQ-016 SHALL drive in_ready = en combinationally; a beat is accepted when in_valid & in_ready.
REQ-017 SHALL insert a bubble (valid=0) into stage 1 on any advancing cycle with no accepted beat.
REQ-018 SHALL hold out_a and out_b stable while out_valid=1 and out_ready=0.
REQ-019 SHALL sustain 1 beat/cycle when out_ready is held high; no beat dropped or duplicated under any out_ready pattern.

Reset
REQ-020 SHALL clear all stage valid bits on the rst cycle; out_valid=0 and in_ready=1 on the cycle after.
REQ-021 SHALL reset out_a and out_b to 0; data registers other than outputs need no reset.
REQ-022 SHALL discard in-flight beats when rst is asserted mid-operation; no output appears from them.

Configuration
REQ-023 SHALL support macro NTT_BFU_HALF_EN.
- Defined: in GS mode both outputs are multiplied by 2^-1 mod Q (x even: x>>1; x odd: (x>>1)+(Q+1)/2), applied in the final stage with no latency change.
- Undefined: no scaling; the halving logic is absent.
- CT mode is unaffected in both cases.

Structure
REQ-024 SHALL place the mode encoding constants (MODE_CT, MODE_GS), the LATENCY=5 constant and a Barrett-constant function of (Q, WIDTH) in shared package ntt_pkg.
REQ-025 SHALL implement the 4-stage Barrett multiplier as sub-module mod_mult_pipe (clk, en, a, b, out), instantiated once; the operand mux selects b (CT) or the difference (GS).

Verification (Q=8380417, WIDTH=23)
REQ-026 SHALL test CT a=5, b=3, w=2 -> after 5 cycles out_a=11, out_b=8380416.
REQ-027 SHALL test GS a=5, b=3, w=2 -> out_a=8, out_b=4; with NTT_BFU_HALF_EN, out_a=4, out_b=2; and GS a=4, b=1, w=1 -> out_a=4190211, out_b=4190210.
REQ-028 SHALL test CT a=b=w=8380416 -> out_a=0, out_b=8380415.
REQ-029 SHALL test 64 back-to-back random beats with interleaved modes and random out_ready:
- outputs match the reference model in order;
- outputs stay stable while stalled;
- full throughput whenever out_ready=1.
REQ-030 SHALL test rst asserted for 1 cycle with 3 beats in flight -> out_valid=0 thereafter until new beats arrive; the first new beat emerges after exactly 5 cycles.

Source files
------------

// File: rtl/ntt_pkg.sv
// -----------------------------------------------------------------------------
// ntt_pkg
// Shared constants and helpers for the NTT butterfly unit.
//   MODE_CT / MODE_GS : encoding of the butterfly mode input
//   LATENCY           : input-to-output latency in advancing cycles
//   barrett_m()       : Barrett constant floor(2^(2*width) / q)
// -----------------------------------------------------------------------------
package ntt_pkg;

    localparam logic MODE_CT = 1'b0;
    localparam logic MODE_GS = 1'b1;
    localparam int   LATENCY = 5;

    // Evaluated at elaboration only; 128 bits covers any width up to 63.
    function automatic logic [127:0] barrett_m(input logic [63:0] q,
                                               input int unsigned width);
        logic [127:0] num;
        num = 128'd1 << (2 * width);
        return num / {64'd0, q};
    endfunction

endpackage

// File: rtl/mod_mult_pipe.sv
// -----------------------------------------------------------------------------
// mod_mult_pipe
// Four-stage modular multiplier, out = a*b mod Q, using Barrett reduction.
// Every register advances only when en=1; there is no reset because this
// block carries data only (validity is tracked by the parent).
//   clk : clock
//   en  : pipeline advance enable
//   a,b : operands, each < Q
//   out : registered result in [0,Q), four advancing cycles after a/b
// Stages:
//   1: full 2*WIDTH product P
//   2: Barrett quotient estimate floor(P*M / 2^(2*WIDTH)), P carried along
//   3: remainder P - est*Q, which lies in [0,2Q)
//   4: single conditional subtraction of Q
// -----------------------------------------------------------------------------
module mod_mult_pipe
    import ntt_pkg::*;
#(
    parameter int               WIDTH = 23,
    parameter logic [WIDTH-1:0] Q     = 23'd8380417
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out
);

    localparam int PW = 2 * WIDTH;
    localparam int EW = PW + WIDTH;
    localparam logic [127:0]  M_FULL = barrett_m(64'(Q), WIDTH);
    localparam logic [PW-1:0] M      = M_FULL[PW-1:0];

    logic [PW-1:0]    prod_d, prod_q, prod2_q;
    logic [WIDTH-1:0] qest_d, qest_q;
    logic [WIDTH:0]   rem_d, rem_q;
    logic [WIDTH-1:0] res_d, res_q;

    // P < Q^2 and M <= 2^(2W)/Q, so P*M < Q*2^(2W) fits in 3W bits exactly.
    // The estimate undershoots the true quotient by at most one, so the
    // remainder stays below 2Q and one correction step is enough.
    always_comb begin
        prod_d = PW'(a) * PW'(b);
        qest_d = WIDTH'((EW'(prod_q) * EW'(M)) >> PW);
        rem_d  = (WIDTH+1)'(prod2_q - PW'(qest_q) * PW'(Q));
        res_d  = (rem_q >= {1'b0, Q}) ? WIDTH'(rem_q - {1'b0, Q})
                                      : rem_q[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (en) begin
            prod_q  <= prod_d;
            prod2_q <= prod_q;
            qest_q  <= qest_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
        end
    end

    assign out = res_q;

endmodule

// File: rtl/ntt_butterfly.sv
// -----------------------------------------------------------------------------
// ntt_butterfly
// Pipelined NTT butterfly, Cooley-Tukey (CT) or Gentleman-Sande (GS) per beat.
//   CT: t = b*w;       out_a = a+t;  out_b = a-t        (all mod Q)
//   GS: out_a = a+b;   out_b = (a-b)*w                  (all mod Q)
// Fixed latency of 5 advancing cycles in both modes; mode and valid travel
// with the data so CT and GS beats can be mixed back-to-back.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_a, in_b, in_w        : operands and twiddle, each < Q
//   in_mode                 : 0 = CT, 1 = GS
//   in_valid / in_ready     : input handshake
//   out_a, out_b            : results in [0,Q)
//   out_valid / out_ready   : output handshake
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high. The whole pipeline advances when out_ready | ~out_valid, and
// in_ready is exactly that advance condition, so the pipe never drops or
// duplicates a beat and holds its outputs while stalled.
// Build option: define NTT_BFU_HALF_EN to scale both GS outputs by 2^-1 mod Q
// in the final stage (no latency change).
// -----------------------------------------------------------------------------
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int               WIDTH = 23,
    parameter logic [WIDTH-1:0] Q     = 23'd8380417
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_w,
    input  logic             in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_valid,
    input  logic             out_ready
);

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= {1'b0, Q}) ? WIDTH'(s - {1'b0, Q}) : s[WIDTH-1:0];
    endfunction

    // The top bit of the difference is the borrow, i.e. x < y.
    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[WIDTH] ? WIDTH'(d + {1'b0, Q}) : d[WIDTH-1:0];
    endfunction

`ifdef NTT_BFU_HALF_EN
    localparam logic [WIDTH-1:0] HALF_Q = WIDTH'(({1'b0, Q} + (WIDTH+1)'(1)) >> 1);

    // x * 2^-1 mod Q; for odd x, (x+Q)/2 = (x>>1) + (Q+1)/2, which stays < Q.
    function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x);
        return x[0] ? (x >> 1) + HALF_Q : (x >> 1);
    endfunction
`endif

    logic             en;
    logic [WIDTH-1:0] sum_in, diff_in, mul_x, dly_d, mult_res;
    logic [3:0]       vld_q, mode_q;
    logic [WIDTH-1:0] dly_q [4];
    logic [WIDTH-1:0] out_a_d, out_b_d, out_a_q, out_b_q;
    logic             out_valid_q;

    assign en       = out_ready | ~out_valid_q;
    assign in_ready = en;

    // GS add/sub happens in front of the first register so that both modes
    // use the single multiplier in the same pipeline slots. The one delay
    // line carries a (CT) or the sum (GS) alongside the multiplier.
    always_comb begin
        sum_in  = mod_add(in_a, in_b);
        diff_in = mod_sub(in_a, in_b);
        mul_x   = (in_mode == MODE_GS) ? diff_in : in_b;
        dly_d   = (in_mode == MODE_GS) ? sum_in : in_a;
    end

    mod_mult_pipe #(
        .WIDTH (WIDTH),
        .Q     (Q)
    ) u_mult (
        .clk (clk),
        .en  (en),
        .a   (mul_x),
        .b   (in_w),
        .out (mult_res)
    );

    always_comb begin
        out_a_d = mod_add(dly_q[3], mult_res);
        out_b_d = mod_sub(dly_q[3], mult_res);
        if (mode_q[3] == MODE_GS) begin
`ifdef NTT_BFU_HALF_EN
            out_a_d = halve(dly_q[3]);
            out_b_d = halve(mult_res);
`else
            out_a_d = dly_q[3];
            out_b_d = mult_res;
`endif
        end
    end

    // Control and output registers; a cycle without an accepted beat shifts
    // in valid=0, which is just in_valid since in_ready == en here.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else if (en) begin
            vld_q       <= {vld_q[2:0], in_valid};
            out_valid_q <= vld_q[3];
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

    // Data-path stage registers need no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            mode_q   <= {mode_q[2:0], in_mode};
            dly_q[0] <= dly_d;
            for (int i = 1; i < 4; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ntt_butterfly.sv
// -----------------------------------------------------------------------------
// tb_ntt_butterfly
// Self-checking bench for ntt_butterfly (WIDTH=23, Q=8380417). Directed
// vectors carry hand-computed results; the random stream uses a plain
// modular-arithmetic model. Expected beats wait in exp_a_q/exp_b_q and are
// compared in order as they leave the DUT. Honours NTT_BFU_HALF_EN.
// -----------------------------------------------------------------------------
module tb_ntt_butterfly;
    import ntt_pkg::*;

    localparam int               WIDTH = 23;
    localparam logic [WIDTH-1:0] Q     = 23'd8380417;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_a = '0, in_b = '0, in_w = '0;
    logic             in_mode = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_a, out_b;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             rand_rdy = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_a_q[$];
    logic [WIDTH-1:0] exp_b_q[$];

    ntt_butterfly #(
        .WIDTH (WIDTH),
        .Q     (Q)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model in wide integer arithmetic with the % operator.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] w, input logic mode,
                         output logic [WIDTH-1:0] ea, output logic [WIDTH-1:0] eb);
        longint unsigned qq, aa, bb, ww, t, ra, rb;
        qq = longint'(Q); aa = longint'(a); bb = longint'(b); ww = longint'(w);
        if (mode == MODE_CT) begin
            t  = (bb * ww) % qq;
            ra = (aa + t) % qq;
            rb = (aa + qq - t) % qq;
        end else begin
            ra = (aa + bb) % qq;
            rb = (((aa + qq - bb) % qq) * ww) % qq;
`ifdef NTT_BFU_HALF_EN
            ra = (ra * ((qq + 1) / 2)) % qq;
            rb = (rb * ((qq + 1) / 2)) % qq;
`endif
        end
        ea = WIDTH'(ra);
        eb = WIDTH'(rb);
    endtask

    // ---------------- output side ----------------
    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                check("spurious_valid", 64'(out_valid), 64'd0);
            end else if (out_ready) begin
                check("out_a", 64'(out_a), 64'(exp_a_q.pop_front()));
                check("out_b", 64'(out_b), 64'(exp_b_q.pop_front()));
            end else begin
                check("hold_a", 64'(out_a), 64'(exp_a_q[0]));
                check("hold_b", 64'(out_b), 64'(exp_b_q[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge
    // with in_valid still high so the next send can follow back-to-back.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] w, input logic mode,
                        input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
        bit acc;
        int tries;
        in_a = a; in_b = b; in_w = w; in_mode = mode; in_valid = 1'b1;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            if (out_ready) check("thru_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            exp_a_q.push_back(ea);
            exp_b_q.push_back(eb);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Single beat into an idle pipe with out_ready high; measures latency.
    task automatic directed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] w, input logic mode,
                            input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
        int lat;
        send(a, b, w, mode, ea, eb);
        idle();
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'd5);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1'b1;
        exp_a_q.delete();
        exp_b_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] a, b, w, ea, eb;
        logic             m;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_a", 64'(out_a), 64'd0);
        check("rst_out_b", 64'(out_b), 64'd0);
        @(posedge clk);
        #1;

        // Directed vectors, results worked out by hand.
        directed(23'd5, 23'd3, 23'd2, MODE_CT, 23'd11, 23'd8380416);
`ifdef NTT_BFU_HALF_EN
        directed(23'd5, 23'd3, 23'd2, MODE_GS, 23'd4, 23'd2);
        directed(23'd4, 23'd1, 23'd1, MODE_GS, 23'd4190211, 23'd4190210);
        directed(23'd0, 23'd1, 23'd8380416, MODE_GS, 23'd4190209, 23'd4190209);
`else
        directed(23'd5, 23'd3, 23'd2, MODE_GS, 23'd8, 23'd4);
        directed(23'd4, 23'd1, 23'd1, MODE_GS, 23'd5, 23'd3);
        directed(23'd0, 23'd1, 23'd8380416, MODE_GS, 23'd1, 23'd1);
`endif
        directed(23'd8380416, 23'd8380416, 23'd8380416, MODE_CT, 23'd0, 23'd8380415);
        directed(23'd0, 23'd7, 23'd1, MODE_CT, 23'd7, 23'd8380410);

        // Random back-to-back stream, mixed modes, random out_ready.
        rand_rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            a = WIDTH'($urandom_range(0, 32'(Q) - 1));
            b = (i % 9 == 0) ? Q - 23'd1 : WIDTH'($urandom_range(0, 32'(Q) - 1));
            w = (i % 11 == 0) ? 23'd0 : WIDTH'($urandom_range(0, 32'(Q) - 1));
            m = ($urandom_range(0, 1) == 1);
            model(a, b, w, m, ea, eb);
            send(a, b, w, m, ea, eb);
        end
        idle();
        for (int k = 0; k < 400 && exp_a_q.size() != 0; k++) @(negedge clk);
        check("drain_empty", 64'(exp_a_q.size()), 64'd0);
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with three beats in flight: they must never come out.
        for (int i = 0; i < 3; i++) begin
            a = WIDTH'(i + 10); b = WIDTH'(i + 1); w = 23'd3;
            model(a, b, w, MODE_CT, ea, eb);
            send(a, b, w, MODE_CT, ea, eb);
        end
        pulse_reset();
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 8; k++) begin
            check("midrst_no_out", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        directed(23'd5, 23'd3, 23'd2, MODE_CT, 23'd11, 23'd8380416);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
